// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch core: state encoding,
// time-field widths/limits and the packed time record held in the lap buffer.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } sw_state_e;

    localparam int MSEC_W = 7;
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam logic [MSEC_W-1:0] MSEC_MAX = 7'd99;
    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
        logic [MSEC_W-1:0] msec;
    } sw_time_t;

    function automatic logic time_is_zero(input sw_time_t t);
        return (t == '0);
    endfunction

endpackage

// File: rtl/stopwatch_tick_gen.sv
// Tick divider: counts clock cycles while enabled and pulses on the terminal
// count. Held at zero when disabled so no partial interval survives a stop.
module stopwatch_tick_gen #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int TICK_HZ  = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int DIV   = CLK_FREQ / TICK_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        tick  = 1'b0;
        if (en) begin
            if (cnt_q == TERM) tick = 1'b1;
            else               cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/stopwatch_lap_core.sv
// Stopwatch / count-down timer with a ring-buffer of lap captures and recall.
// Displayed time is the live counter or, while recalling, the selected lap.
module stopwatch_lap_core
    import stopwatch_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int TICK_HZ   = 100,
    parameter int LAP_DEPTH = 4,
    parameter int HOUR_MAX  = 24
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_run,
    input  logic                           i_clear,
    input  logic                           i_lap,
    input  logic                           i_recall,
    input  logic                           i_dir,
    output logic [MSEC_W-1:0]              o_msec,
    output logic [SEC_W-1:0]               o_sec,
    output logic [MIN_W-1:0]               o_min,
    output logic [HOUR_W-1:0]              o_hour,
    output logic [1:0]                     o_state,
    output logic [$clog2(LAP_DEPTH+1)-1:0] o_lap_cnt,
    output logic                           o_lap_view,
    output logic                           o_done
);
    localparam int CNT_W = $clog2(LAP_DEPTH + 1);
    localparam int PTR_W = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
    localparam logic [CNT_W-1:0]  LAP_FULL  = CNT_W'(LAP_DEPTH);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(LAP_DEPTH - 1);
    localparam logic [HOUR_W-1:0] HOUR_LAST = HOUR_W'(HOUR_MAX - 1);

    sw_state_e         state_q, state_d;
    sw_time_t          time_q, time_d;
    logic              dir_q, dir_d;
    logic              done_q, done_d;
    sw_time_t          lap_buf_q [LAP_DEPTH];
    sw_time_t          lap_buf_d [LAP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  lap_cnt_q, lap_cnt_d;
    logic              view_q, view_d;
    logic [PTR_W-1:0]  view_idx_q, view_idx_d;
    logic              tick;

    stopwatch_tick_gen #(
        .CLK_FREQ (CLK_FREQ),
        .TICK_HZ  (TICK_HZ)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == ST_RUN),
        .tick (tick)
    );

    function automatic sw_time_t time_inc(input sw_time_t t);
        sw_time_t r = t;
        if (t.msec != MSEC_MAX) r.msec = t.msec + 7'd1;
        else begin
            r.msec = '0;
            if (t.sec != SEC_MAX) r.sec = t.sec + 6'd1;
            else begin
                r.sec = '0;
                if (t.min != MIN_MAX) r.min = t.min + 6'd1;
                else begin
                    r.min  = '0;
                    r.hour = (t.hour == HOUR_LAST) ? '0 : t.hour + 5'd1;
                end
            end
        end
        return r;
    endfunction

    // Only called on a non-zero time, so the hour borrow cannot underflow.
    function automatic sw_time_t time_dec(input sw_time_t t);
        sw_time_t r = t;
        if (t.msec != '0) r.msec = t.msec - 7'd1;
        else begin
            r.msec = MSEC_MAX;
            if (t.sec != '0) r.sec = t.sec - 6'd1;
            else begin
                r.sec = SEC_MAX;
                if (t.min != '0) r.min = t.min - 6'd1;
                else begin
                    r.min  = MIN_MAX;
                    r.hour = t.hour - 5'd1;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        time_d     = time_q;
        dir_d      = dir_q;
        done_d     = 1'b0;
        lap_buf_d  = lap_buf_q;
        wr_ptr_d   = wr_ptr_q;
        lap_cnt_d  = lap_cnt_q;
        view_d     = view_q;
        view_idx_d = view_idx_q;
        unique case (state_q)
            ST_STOP: begin
                if (i_clear) begin
                    state_d = ST_CLEAR;
                    view_d  = 1'b0;
                end else if (i_run) begin
                    view_d = 1'b0;
                    if (!(i_dir && time_is_zero(time_q))) begin
                        state_d = ST_RUN;
                        dir_d   = i_dir;
                    end
                end else if (i_recall && lap_cnt_q != '0) begin
                    if (!view_q) begin
                        view_d     = 1'b1;
                        view_idx_d = '0;
                    end else if (CNT_W'(view_idx_q) == lap_cnt_q - CNT_W'(1)) begin
                        view_d = 1'b0;
                    end else begin
                        view_idx_d = view_idx_q + PTR_W'(1);
                    end
                end
            end
            ST_RUN: begin
                // Capture uses the pre-tick time even if a tick lands this edge.
                if (i_lap) begin
                    lap_buf_d[wr_ptr_q] = time_q;
                    wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
                    if (lap_cnt_q != LAP_FULL) lap_cnt_d = lap_cnt_q + CNT_W'(1);
                end
                if (i_run) state_d = ST_STOP;
                if (tick) begin
                    if (!dir_q) begin
                        time_d = time_inc(time_q);
                    end else if (!time_is_zero(time_q)) begin
                        time_d = time_dec(time_q);
                        if (time_is_zero(time_d)) begin
                            state_d = ST_STOP;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            ST_CLEAR: begin
                state_d    = ST_STOP;
                time_d     = '0;
                lap_buf_d  = '{default: '0};
                wr_ptr_d   = '0;
                lap_cnt_d  = '0;
                view_d     = 1'b0;
                view_idx_d = '0;
            end
            default: state_d = ST_STOP;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_STOP;
            time_q     <= '0;
            dir_q      <= 1'b0;
            done_q     <= 1'b0;
            lap_buf_q  <= '{default: '0};
            wr_ptr_q   <= '0;
            lap_cnt_q  <= '0;
            view_q     <= 1'b0;
            view_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            time_q     <= time_d;
            dir_q      <= dir_d;
            done_q     <= done_d;
            lap_buf_q  <= lap_buf_d;
            wr_ptr_q   <= wr_ptr_d;
            lap_cnt_q  <= lap_cnt_d;
            view_q     <= view_d;
            view_idx_q <= view_idx_d;
        end
    end

    // Newest lap sits just behind the write pointer; view_idx walks backwards.
    logic [PTR_W:0]   rd_sum;
    logic [PTR_W-1:0] rd_ptr;
    sw_time_t         disp;

    always_comb begin
        rd_sum = (PTR_W+1)'(wr_ptr_q) + (PTR_W+1)'(LAP_DEPTH - 1) - (PTR_W+1)'(view_idx_q);
        if (rd_sum >= (PTR_W+1)'(LAP_DEPTH)) rd_sum = rd_sum - (PTR_W+1)'(LAP_DEPTH);
        rd_ptr = rd_sum[PTR_W-1:0];
        disp   = view_q ? lap_buf_q[rd_ptr] : time_q;
    end

    assign o_msec     = disp.msec;
    assign o_sec      = disp.sec;
    assign o_min      = disp.min;
    assign o_hour     = disp.hour;
    assign o_state    = state_q;
    assign o_lap_cnt  = lap_cnt_q;
    assign o_lap_view = view_q;
    assign o_done     = done_q;

endmodule

// File: doc/stopwatch_lap_core.md
# stopwatch_lap_core

Parametrised stopwatch/timer core. It replaces the separate stopwatch datapath and control-unit pair with a single block that adds count-down timer mode, a lap buffer of configurable depth, and lap recall. It sits between the button debouncers (inputs are already debounced one-cycle pulses) and the FND controller, which consumes its `msec`/`sec`/`min`/`hour` outputs unchanged.

## Interface
- `CLK_FREQ`, 100_000_000: input clock frequency in Hz.
- `TICK_HZ`, 100: count resolution in Hz. `CLK_FREQ` must be an integer multiple of it.
- `LAP_DEPTH`, 4: number of lap entries stored (≥1).
- `HOUR_MAX`, 24: hour modulus (≤32).
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `i_run` in 1: start/stop toggle pulse.
- `i_clear` in 1: clear pulse.
- `i_lap` in 1: lap capture pulse.
- `i_recall` in 1: step through stored laps.
- `i_dir` in 1: 0 = count up, 1 = count down. Latched on STOP→RUN.
- `o_msec` out 7: hundredths, 0..99.
- `o_sec` out 6: seconds, 0..59.
- `o_min` out 6: minutes, 0..59.
- `o_hour` out 5: hours, 0..HOUR_MAX-1.
- `o_state` out 2: 0 = STOP, 1 = RUN, 2 = CLEAR.
- `o_lap_cnt` out clog2(LAP_DEPTH+1): number of valid laps stored.
- `o_lap_view` out 1: 1 while the outputs show a stored lap rather than the live time.
- `o_done` out 1: one-cycle pulse when a count-down reaches zero.

## Operation
- **Reset.** State is STOP, all time registers are 0, the lap buffer is empty, `o_lap_cnt` is 0, `o_lap_view` is 0, `o_done` is 0, and the tick divider is 0.
- **FSM transitions.**
  - STOP + `i_run` → RUN. Ignored in down mode when the time is 00:00:00.00.
  - RUN + `i_run` → STOP.
  - STOP + `i_clear` → CLEAR.
  - CLEAR → STOP unconditionally after 1 cycle. During CLEAR the time and lap buffer are zeroed and the view is reset to live.
  - `i_clear` in RUN is ignored.
- **Tick.** The divider counts 0..`CLK_FREQ`/`TICK_HZ`-1 only in RUN. It asserts tick on the terminal count, then wraps to 0. It is held at 0 outside RUN, so there is no partial-tick carry across STOP.
- **Up count.** On tick, msec increments; 99→0 carries into sec, 59→0 into min, 59→0 into hour, and `HOUR_MAX`-1 wraps to 0 silently.
- **Down count.** On tick, the time decrements with borrow; msec 0→99, sec 0→59, min 0→59. When the time transitions to all-zero, the FSM goes RUN→STOP on the same edge and `o_done` pulses for that cycle. The time never underflows.
- **Lap.**
  - `i_lap` in RUN pushes the current (pre-tick) time into the ring buffer.
  - When the buffer is full, the oldest entry is overwritten and `o_lap_cnt` saturates at `LAP_DEPTH`.
  - `i_lap` in STOP or CLEAR is ignored.
- **Recall.**
  - Only in STOP with `o_lap_cnt` > 0. The first press shows the newest lap (`o_lap_view`=1); each further press steps to the next older lap.
  - A press on the oldest lap returns to the live view (`o_lap_view`=0).
  - `i_run` or `i_clear` forces the live view.
- **Simultaneous events.**
  - `i_run` with `i_lap` in RUN: the lap is captured, then the FSM stops.
  - `i_lap` coinciding with a tick: the pre-increment value is captured.
  - `i_run` with `i_clear` in STOP: clear wins.
  - `i_run` with `i_recall` in STOP: run wins.
  - Direction can change only in STOP; an `i_dir` change during RUN is ignored.
- **Width rule.** All time fields are unsigned. Internal comparisons use the field widths above, and no field ever holds an out-of-range value.

## Timing
- Every input pulse acts on the clock edge where it is sampled high.
- Outputs are registered: a tick at edge N shows the new time after edge N.
- Recall shows the selected lap one edge after the pulse.
- `o_state` changes on the same edge as the transition.
- Reset (`rst`=0) at any time, including mid-RUN or mid-recall, forces the reset values asynchronously. Operation resumes on the first edge after deassertion.

## Structure
- Package `stopwatch_pkg` holds:
  - the state encoding (STOP/RUN/CLEAR);
  - field widths 7/6/6/5;
  - constants `MSEC_MAX`=99, `SEC_MAX`=59, `MIN_MAX`=59;
  - the packed time-record type used by the lap buffer.
- Sub-module `stopwatch_tick_gen` (`CLK_FREQ`, `TICK_HZ`; inputs `clk`, `rst`, `en`; output `tick`) implements the divider.
- The lap buffer is an inline register array with write pointer, count and view index.

## Test plan
Run all scenarios with `CLK_FREQ`=1000, `TICK_HZ`=100 (10 cycles/tick) and `LAP_DEPTH`=4.

1. **Up count and stop.** Reset, then `i_run`, then 6000 ticks → `o_sec` 0→0 with `o_min`=1, `o_msec`=0. Then `i_run` → STOP and the time is frozen for 100 cycles.
2. **Down count to zero.** Preload 00:00:01.00 via up-count then clear path (or force), `i_dir`=1, `i_run`. After 100 ticks the time is 0, `o_done` pulses for exactly 1 cycle, and `o_state`=STOP. A further `i_run` is ignored.
3. **Lap overflow and recall.** Capture 5 laps at msec 10, 20, 30, 40, 50 → `o_lap_cnt`=4. In STOP, recall ×5 shows 50, 40, 30, 20, then live.
4. **Clear in both states.** `i_clear` in RUN has no effect. In STOP, `o_state`=2 for 1 cycle, then all outputs and `o_lap_cnt` are 0.
5. **Simultaneous events.** `i_run` with `i_lap` in the tick cycle at msec 7 → lap holds 7 and state is STOP. `i_run` with `i_clear` in STOP → CLEAR.
6. **Asynchronous reset.** Assert `rst`=0 mid-RUN while in the lap view → outputs go to 0 immediately without a clock edge, and the counter is idle after release.
